// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
//   Shared types and defaults for the two-port RAM arbiter.
//   - state_t : arbiter FSM states (IDLE, ACCESS, RETURN)
//   - port_t  : requester identity (PORT_A = 6502 bus, PORT_B = loader/DMA)
//   - DEF_ADDR_W / DEF_DATA_W : default RAM geometry
//   - other_port() : the opposite requester, used by the round-robin pick
// ----------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETURN = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin pick. The last-grant pointer lives in
//   the parent; this block only decides who would win this cycle.
//   Ports:
//     a_req, b_req : request lines
//     last         : port granted most recently
//     valid        : at least one request is present
//     winner       : chosen port (PORT_A when nothing is requested)
// ----------------------------------------------------------------------------
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic  a_req,
  input  logic  b_req,
  input  port_t last,
  output logic  valid,
  output port_t winner
);

  always_comb begin
    valid  = a_req | b_req;
    winner = PORT_A;
    if (a_req && b_req) begin
      // Contention: the port that did not win last time goes first.
      winner = other_port(last);
    end else if (b_req) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port synchronous RAM (registered read, one-cycle
//   latency) between the 6502 bus interface (port A) and a loader/DMA agent
//   (port B). Requests are sampled only in IDLE; the winner's command is
//   latched and replayed on the RAM pins from registered state, so there is
//   no combinational path from any request to the RAM side.
//
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//     x_req/x_rw/x_addr/x_wdata (x = a, b) : request, 1=read/0=write, command
//     x_gnt                   : one-cycle pulse, request accepted
//     x_rvalid / x_rdata      : one-cycle strobe / registered read data
//                               (x_rdata holds until that port reads again)
//     ram_ce/ram_rw/ram_addr/ram_wdata : RAM command pins
//     ram_rdata               : RAM read data, one cycle after the address
//
//   Sequence: IDLE -> ACCESS -> (write) IDLE
//                            -> (read)  RETURN -> IDLE
//   ce/rw are held through RETURN so the RAM keeps its read data qualified
//   while the arbiter captures it.
// ----------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_ce,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // --------------------------------------------------------------------------
  // State and latched command
  // --------------------------------------------------------------------------
  state_t              state_reg;
  state_t              state_next;
  port_t               last_reg;     // most recently granted port
  port_t               owner_reg;    // port that owns the access in flight
  logic                rw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic [NUM_PORTS-1:0] gnt_reg;
  logic [NUM_PORTS-1:0] gnt_next;
  logic [NUM_PORTS-1:0] rvalid_reg;
  logic [DATA_W-1:0]    rdata_reg [NUM_PORTS];

  // Per-port request views, indexed by port_t.
  logic [NUM_PORTS-1:0] rw_vec;
  logic [ADDR_W-1:0]    addr_vec  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_vec [NUM_PORTS];

  logic                 pick_valid;
  port_t                pick_winner;
  logic                 take;

  assign rw_vec       = {b_rw, a_rw};
  assign addr_vec[0]  = a_addr;
  assign addr_vec[1]  = b_addr;
  assign wdata_vec[0] = a_wdata;
  assign wdata_vec[1] = b_wdata;

  // --------------------------------------------------------------------------
  // Round-robin pick (pointer register stays here)
  // --------------------------------------------------------------------------
  rr_pick2 u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // --------------------------------------------------------------------------
  // Next-state and RAM-side decode. RAM pins depend on state_reg/rw_reg only.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    gnt_next   = '0;
    take       = 1'b0;
    ram_ce     = 1'b0;
    ram_rw     = 1'b1;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          take                  = 1'b1;
          gnt_next[pick_winner] = 1'b1;
          state_next            = ACCESS;
        end
      end

      ACCESS: begin
        ram_ce     = 1'b1;
        ram_rw     = rw_reg;
        state_next = rw_reg ? RETURN : IDLE;
      end

      RETURN: begin
        // Keep the read qualified while its data is captured.
        ram_ce     = 1'b1;
        ram_rw     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;

  // --------------------------------------------------------------------------
  // State register and command latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= PORT_B;   // so port A wins the first tie
      owner_reg <= PORT_A;
      rw_reg    <= 1'b1;
      addr_reg  <= '0;
      wdata_reg <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      if (take) begin
        last_reg  <= pick_winner;
        owner_reg <= pick_winner;
        rw_reg    <= rw_vec[pick_winner];
        addr_reg  <= addr_vec[pick_winner];
        wdata_reg <= wdata_vec[pick_winner];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-port read return: only the owner's data/strobe move; the other port
  // keeps its last read value.
  // --------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    localparam port_t PORT_ID = (gi == 0) ? PORT_A : PORT_B;
    logic hit;

    assign hit = (state_reg == RETURN) && (owner_reg == PORT_ID);

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= '0;
      end else begin
        rvalid_reg[gi] <= hit;
        if (hit) begin
          rdata_reg[gi] <= ram_rdata;
        end
      end
    end
  end

  assign a_gnt    = gnt_reg[0];
  assign b_gnt    = gnt_reg[1];
  assign a_rvalid = rvalid_reg[0];
  assign b_rvalid = rvalid_reg[1];
  assign a_rdata  = rdata_reg[0];
  assign b_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//   Bench for ram_arbiter with a behavioural single-port RAM attached.
//   Directed table of single-requester operations, hand-written sequences
//   for ties, back-to-back reads and reset during a read return, then a
//   randomized phase checked against a transaction-level model (grant order
//   from the round-robin rule, timing from access lengths, data from a
//   reference memory array).
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RK = 1500;   // random phase length in cycles

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          a_req, a_rw, b_req, b_rw;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_ce, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_rw      (a_rw),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_rw      (b_rw),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_ce    (ram_ce),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural RAM: registered read, write on ce && !rw, plus a preload port.
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] ram_q;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)                   mem[pl_addr]  <= pl_data;
    else if (ram_ce && !ram_rw)  mem[ram_addr] <= ram_wdata;
    if (ram_ce && ram_rw)        ram_q <= mem[ram_addr];
  end
  assign ram_rdata = ram_q;

  logic [1:0] gnt_v, rv_v;
  assign gnt_v = {b_gnt, a_gnt};
  assign rv_v  = {b_rvalid, a_rvalid};

  // Reference memory and expected per-port held read data.
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] exp_rd [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit            port;    // 0 = A, 1 = B
    bit            rw;      // 1 = read
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Random-phase expectations indexed by cycle.
  logic [1:0]    exp_gnt   [0:RK+3];
  logic [1:0]    exp_rv    [0:RK+3];
  logic [DW-1:0] exp_rv_dt [0:RK+3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit req, input bit rw,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p) begin
      b_req = req; b_rw = rw; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_rw = rw; a_addr = addr; a_wdata = wd;
    end
  endtask

  function automatic logic [DW-1:0] cur_rd(input bit p);
    return p ? b_rdata : a_rdata;
  endfunction

  task automatic do_reset();
    drive(0, 0, 1, '0, '0);
    drive(1, 0, 1, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One isolated operation from an idle arbiter, with cycle-exact checks.
  task automatic do_op(input vec_t v);
    bit p;
    p = v.port;
    chk("idle_ce", ram_ce, 0);
    chk("idle_rw", ram_rw, 1);
    drive(p, 1, v.rw, v.addr, v.wdata);
    step();
    chk("op_gnt", gnt_v[p], 1);
    chk("op_other_gnt", gnt_v[!p], 0);
    chk("access_ce", ram_ce, 1);
    chk("access_rw", ram_rw, v.rw);
    chk("access_addr", ram_addr, v.addr);
    if (!v.rw) chk("access_wdata", ram_wdata, v.wdata);
    drive(p, 0, v.rw, v.addr, v.wdata);
    step();
    if (!v.rw) begin
      ref_mem[v.addr] = v.wdata;
      chk("wr_done_ce", ram_ce, 0);
      chk("wr_done_rw", ram_rw, 1);
      chk("wr_no_gnt", gnt_v, 0);
    end else begin
      chk("return_ce", ram_ce, 1);
      chk("return_rw", ram_rw, 1);
      chk("return_addr", ram_addr, v.addr);
      chk("return_no_rvalid", rv_v, 0);
      step();
      exp_rd[p] = v.exp_rd;
      chk("rd_rvalid", rv_v, p ? 2'b10 : 2'b01);
      chk("rd_data", cur_rd(p), exp_rd[p]);
      chk("rd_done_ce", ram_ce, 0);
    end
    chk("other_rdata_hold", cur_rd(!p), exp_rd[!p]);
    $display("op port=%0d rw=%0d addr=0x%03h wdata=0x%02h rdata=0x%02h",
             p, v.rw, v.addr, v.wdata, cur_rd(p));
  endtask

  initial begin
    logic [AW-1:0] sole_addr [3];
    bit            pend [2];
    bit            rw_p [2];
    logic [AW-1:0] addr_p [2];
    logic [DW-1:0] wd_p [2];
    int            free_at;
    bit            last_m;
    int            na, nb, n;

    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive(0, 0, 1, '0, '0);
    drive(1, 0, 1, '0, '0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Preload RAM and reference while reset is held.
    for (int i = 0; i < 34; i++) begin
      logic [AW-1:0] ad;
      logic [DW-1:0] dt;
      if (i < 32)       begin ad = AW'(i);  dt = DW'(i * 7 + 8'h3C); end
      else if (i == 32) begin ad = 12'h123; dt = 8'h5A; end
      else              begin ad = 12'h040; dt = 8'h33; end
      pl_en = 1'b1; pl_addr = ad; pl_data = dt;
      ref_mem[ad] = dt;
      step();
    end
    pl_en = 1'b0;

    // Reset state.
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_rvalid", rv_v, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_rw", ram_rw, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    reset = 1'b0;
    step();
    chk("post_rst_ce", ram_ce, 0);

    // Directed table.
    vecs[0] = '{port: 0, rw: 1, addr: 12'h123, wdata: 8'h00, exp_rd: 8'h5A};
    vecs[1] = '{port: 1, rw: 0, addr: 12'h010, wdata: 8'hA5, exp_rd: 8'h00};
    vecs[2] = '{port: 1, rw: 1, addr: 12'h010, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[3] = '{port: 1, rw: 1, addr: 12'h040, wdata: 8'h00, exp_rd: 8'h33};
    vecs[4] = '{port: 0, rw: 0, addr: 12'h020, wdata: 8'h77, exp_rd: 8'h00};
    vecs[5] = '{port: 0, rw: 1, addr: 12'h020, wdata: 8'h00, exp_rd: 8'h77};
    vecs[6] = '{port: 1, rw: 1, addr: 12'h123, wdata: 8'h00, exp_rd: 8'h5A};
    vecs[7] = '{port: 0, rw: 1, addr: 12'h005, wdata: 8'h00, exp_rd: 8'h5F};
    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Sole requester: B reads back-to-back, granted every 3 cycles.
    sole_addr[0] = 12'h010; sole_addr[1] = 12'h123; sole_addr[2] = 12'h040;
    n = 0;
    drive(1, 1, 1, sole_addr[0], '0);
    for (int s = 1; s <= 9; s++) begin
      step();
      chk("sole_b_gnt", b_gnt, (s % 3) == 1);
      chk("sole_a_gnt", a_gnt, 0);
      chk("sole_b_rvalid", b_rvalid, (s % 3) == 0);
      if ((s % 3) == 0) begin
        exp_rd[1] = ref_mem[sole_addr[s / 3 - 1]];
        chk("sole_b_rdata", b_rdata, exp_rd[1]);
        $display("sole read addr=0x%03h rdata=0x%02h", sole_addr[s / 3 - 1], b_rdata);
      end
      if ((s % 3) == 1) begin
        n++;
        if (n < 3) drive(1, 1, 1, sole_addr[n], '0);
        else       drive(1, 0, 1, '0, '0);
      end
    end

    // Tie after reset: continuous writes from both, grants alternate A,B,...
    do_reset();
    na = 0; nb = 0;
    drive(0, 1, 0, 12'h100, 8'hA0);
    drive(1, 1, 0, 12'h200, 8'hB0);
    for (int s = 1; s <= 16; s++) begin
      logic [1:0] eg;
      step();
      eg = 2'b00;
      if (s % 2 == 1) eg = (((s - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      chk("tie_order", gnt_v, eg);
      if (eg == 2'b01) begin
        ref_mem[12'h100 + AW'(na)] = 8'hA0 + DW'(na);
        na++;
        if (na < 4) drive(0, 1, 0, 12'h100 + AW'(na), 8'hA0 + DW'(na));
        else        drive(0, 0, 1, '0, '0);
        $display("tie grant A #%0d", na);
      end else if (eg == 2'b10) begin
        ref_mem[12'h200 + AW'(nb)] = 8'hB0 + DW'(nb);
        nb++;
        if (nb < 4) drive(1, 1, 0, 12'h200 + AW'(nb), 8'hB0 + DW'(nb));
        else        drive(1, 0, 1, '0, '0);
        $display("tie grant B #%0d", nb);
      end
    end
    vecs[0] = '{port: 1, rw: 1, addr: 12'h203, wdata: 8'h00, exp_rd: 8'hB3};
    do_op(vecs[0]);

    // Reset during RETURN of an A read.
    drive(0, 1, 1, 12'h123, '0);
    step();
    chk("rr_a_gnt", a_gnt, 1);
    drive(0, 0, 1, '0, '0);
    step();
    chk("rr_return_ce", ram_ce, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk("rr_no_rvalid", rv_v, 0);
    chk("rr_ce_low", ram_ce, 0);
    chk("rr_a_rdata_rst", a_rdata, 0);
    chk("rr_no_gnt", gnt_v, 0);
    drive(0, 1, 1, 12'h123, '0);
    drive(1, 1, 1, 12'h040, '0);
    step();
    chk("rr_tie_a_first", gnt_v, 2'b01);
    drive(0, 0, 1, '0, '0);
    step();
    chk("rr_s5_gnt", gnt_v, 0);
    step();
    exp_rd[0] = 8'h5A;
    chk("rr_a_rvalid", rv_v, 2'b01);
    chk("rr_a_rdata", a_rdata, exp_rd[0]);
    step();
    chk("rr_b_gnt", gnt_v, 2'b10);
    drive(1, 0, 1, '0, '0);
    step();
    step();
    exp_rd[1] = 8'h33;
    chk("rr_b_rvalid", rv_v, 2'b10);
    chk("rr_b_rdata", b_rdata, exp_rd[1]);
    chk("rr_a_hold", a_rdata, exp_rd[0]);
    $display("reset-in-return sequence a_rdata=0x%02h b_rdata=0x%02h", a_rdata, b_rdata);

    // Randomized phase against a transaction-level model.
    for (int k = 0; k < RK + 4; k++) begin
      exp_gnt[k] = 2'b00; exp_rv[k] = 2'b00; exp_rv_dt[k] = '0;
    end
    pend[0] = 0; pend[1] = 0;
    rw_p[0] = 1; rw_p[1] = 1;
    addr_p[0] = '0; addr_p[1] = '0;
    wd_p[0] = '0; wd_p[1] = '0;
    free_at = 0;
    last_m  = 1'b1;   // B was granted last
    for (int k = 0; k < RK + 4; k++) begin
      if (k > 0) begin
        step();
        chk("rnd_gnt", gnt_v, exp_gnt[k]);
        chk("rnd_rvalid", rv_v, exp_rv[k]);
        for (int p = 0; p < 2; p++) begin
          if (exp_rv[k][p]) exp_rd[p] = exp_rv_dt[k];
          if (exp_gnt[k][p]) begin
            pend[p] = 0;
            $display("rnd cycle=%0d grant port=%0d rw=%0d addr=0x%03h", k, p, rw_p[p], addr_p[p]);
          end
        end
        chk("rnd_a_rdata", a_rdata, exp_rd[0]);
        chk("rnd_b_rdata", b_rdata, exp_rd[1]);
      end
      if (k < RK) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(0, 2) != 0) begin
            pend[p]   = 1;
            rw_p[p]   = 1'($urandom_range(0, 1));
            addr_p[p] = AW'($urandom_range(0, 31));
            wd_p[p]   = DW'($urandom);
          end
          drive(p[0], pend[p], rw_p[p], addr_p[p], wd_p[p]);
        end
        if (k >= free_at && (pend[0] || pend[1])) begin
          bit w;
          w = (pend[0] && pend[1]) ? !last_m : pend[1];
          last_m = w;
          exp_gnt[k + 1][w] = 1'b1;
          if (rw_p[w]) begin
            exp_rv[k + 3][w] = 1'b1;
            exp_rv_dt[k + 3] = ref_mem[addr_p[w]];
            free_at = k + 3;
          end else begin
            ref_mem[addr_p[w]] = wd_p[w];
            free_at = k + 2;
          end
        end
      end else begin
        drive(0, 0, 1, '0, '0);
        drive(1, 0, 1, '0, '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one single-port synchronous RAM (registered read, one-cycle latency, read data qualified by `ce && rw`) between two requesters: the 6502 bus interface (port A) and a loader/DMA agent (port B). It serialises requests, drives the RAM's `address`/`wdata`/`rw`/`ce` pins, and holds `ce`/`rw` through the read-return cycle. It returns registered read data to the winning requester with a one-cycle valid strobe.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 8, RAM data width

- `clk`  in  1  system clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `a_req`, `b_req`  in  1  request; held high until `x_gnt`
- `a_rw`, `b_rw`  in  1  1 = read, 0 = write
- `a_addr`, `b_addr`  in  ADDR_W  address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_gnt`, `b_gnt`  out  1  one-cycle pulse: request accepted
- `a_rvalid`, `b_rvalid`  out  1  one-cycle pulse: `x_rdata` updated
- `a_rdata`, `b_rdata`  out  DATA_W  registered read data; holds until next read for that port
- `ram_ce`  out  1  RAM chip enable
- `ram_rw`  out  1  RAM read(1)/write(0)
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data; valid only while `ram_ce && ram_rw`, one cycle after the address edge

## Operation
- FSM states: IDLE, ACCESS, RETURN.
- **IDLE:**
  - `ram_ce` = 0.
  - If any `x_req` is high: pick a winner, latch its rw/addr/wdata and the owner, register the `x_gnt` pulse, and go to ACCESS.
- **ACCESS:**
  - Drives `ram_ce` = 1, `ram_rw` = latched rw, `ram_addr`/`ram_wdata` = latched values.
  - Write: go to IDLE.
  - Read: go to RETURN.
- **RETURN:**
  - Holds `ram_ce` = 1, `ram_rw` = 1, and the same address.
  - Captures `ram_rdata` into the owner's `x_rdata`, pulses the owner's `x_rvalid` next cycle, and goes to IDLE.
- **Arbitration:**
  - Only one requester high: it wins.
  - Both high: the port not granted last wins.
  - The last-grant pointer updates on every grant.
- Requests are sampled only in IDLE. A requester must drop `x_req`, or present a new request, in the cycle after it sees `x_gnt`.
- The non-owner's `x_rdata`/`x_rvalid` are untouched.
- **Reset values:**
  - state IDLE, last-grant = B (A wins the first tie).
  - All `x_gnt`, `x_rvalid`, `ram_ce` = 0.
  - `ram_rw` = 1.
  - `ram_addr`, `ram_wdata`, `x_rdata` = 0.
- **Reset mid-operation:** any in-flight access is abandoned. No `x_rvalid` issues for it, and `ram_ce` is 0 in the cycle after reset is sampled.

## Timing
- Request high in cycle 0 (IDLE):
  - `x_gnt` = 1 in cycle 1.
  - ACCESS in cycle 1.
  - Write: RAM commits at the end of cycle 1; IDLE in cycle 2.
  - Read: RETURN in cycle 2; `x_rvalid` = 1 with data in cycle 3; IDLE in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `x_gnt` and `x_rvalid` are registered outputs. The RAM-side outputs decode from registered state only, with no combinational path from `x_req`.

## Structure
- Shared package `ram_arb_pkg`: state enum `{IDLE, ACCESS, RETURN}`, and `ADDR_W`/`DATA_W` defaults.
- One natural sub-module `rr_pick2`: combinational 2-way round-robin pick from `(a_req, b_req, last)`, returning the winner id. The pointer register stays in the parent.

## Test plan
- **A read:** preload mem[0x123] = 0x5A; A reads 0x123 → `a_gnt` in cycle 1, `ram_ce` high in cycles 1–2, `a_rvalid` in cycle 3 with `a_rdata` = 0x5A.
- **B write then read-back:** B writes 0xA5 to 0x010 → `b_gnt`, `ram_rw` = 0 for exactly one cycle; a subsequent B read of 0x010 returns 0xA5.
- **Tie after reset:** A and B request continuously for 4 accesses each → grant order A, B, A, B, …
- **Sole requester:** only B issues 3 back-to-back reads → `b_gnt` every 3 cycles, no stall from the pointer.
- **Reset during RETURN of an A read:** no `a_rvalid`; `ram_ce` = 0 next cycle; the following tie grants A first.
- **Data hold:** after A reads 0x5A, B reads 0x33 → `a_rdata` stays 0x5A, `b_rdata` = 0x33, and only `b_rvalid` pulses.
